// File: rtl/e203_exu_brslv_q.sv
`default_nettype none
// ============================================================================
// e203_exu_brslv_q : commit-stage branch resolver, IFU flush handshake and BHT update queue.
// Optional feature macro: E203_BRSLV_PERF_CNT_EN (bxx hit/miss counters).  Rev 1.0
// ============================================================================
module e203_exu_brslv_q #(
  parameter int PC_W      = 32,
  parameter int XLEN      = 32,
  parameter int UPD_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             cmt_i_valid,
  output logic             cmt_i_ready,
  input  logic             cmt_i_rv32,
  input  logic             cmt_i_bjp,
  input  logic             cmt_i_bxx,
  input  logic             cmt_i_fencei,
  input  logic             cmt_i_mret,
  input  logic             cmt_i_dret,
  input  logic             cmt_i_bjp_prdt,
  input  logic             cmt_i_bjp_rslv,
  input  logic [PC_W-1:0]  cmt_i_pc,
  input  logic [XLEN-1:0]  cmt_i_imm,

  input  logic [PC_W-1:0]  csr_epc_r,
  input  logic [PC_W-1:0]  csr_dpc_r,
  input  logic             nonalu_excpirq_flush_req_raw,

  output logic             brchmis_flush_req,
  input  logic             brchmis_flush_ack,
  output logic [PC_W-1:0]  brchmis_flush_pc,

  output logic             cmt_mret_ena,
  output logic             cmt_dret_ena,
  output logic             cmt_fencei_ena,

  output logic             bht_upd_valid,
  input  logic             bht_upd_ready,
  output logic [PC_W-1:0]  bht_upd_pc,
  output logic             bht_upd_taken,
  output logic             bht_upd_mis,

  output logic [CNT_W-1:0] perf_bxx_cnt,
  output logic [CNT_W-1:0] perf_bxxmis_cnt
);

  localparam int             PTR_W     = $clog2(UPD_DEPTH);
  localparam int             ENT_W     = PC_W + 2;
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(UPD_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   flush_pc_q, flush_pc_d;
  logic              mret_q, mret_d;
  logic              dret_q, dret_d;
  logic              fencei_q, fencei_d;

  logic [ENT_W-1:0]  mem_q [UPD_DEPTH];
  logic [ENT_W-1:0]  mem_d [UPD_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;

  logic [PC_W-1:0]   imm_pc;
  logic [PC_W-1:0]   next_pc;
  logic [PC_W-1:0]   target_pc;
  logic              need_flush;
  logic              is_br;
  logic              bxx_mis;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              flush_hsk;

  // Offset is narrowed (or sign-extended) to PC width before the modulo-2^PC_W add.
  generate
    if (XLEN >= PC_W) begin : g_imm_trunc
      assign imm_pc = cmt_i_imm[PC_W-1:0];
      if (XLEN > PC_W) begin : g_imm_hi
        logic unused_imm_hi;
        assign unused_imm_hi = ^cmt_i_imm[XLEN-1:PC_W];
      end
    end else begin : g_imm_sext
      assign imm_pc = {{(PC_W-XLEN){cmt_i_imm[XLEN-1]}}, cmt_i_imm};
    end
  endgenerate

  assign bxx_mis    = cmt_i_bjp_prdt ^ cmt_i_bjp_rslv;
  assign need_flush = (cmt_i_bjp & bxx_mis) | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
  assign is_br      = cmt_i_bjp | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
  assign fifo_full  = (cnt_q == FIFO_FULL);
  assign fifo_empty = (cnt_q == '0);

  // A full queue stalls bxx even when a pop lands in the same cycle.
  always_comb begin
    if (state_q == ST_IDLE)
      cmt_i_ready = ~is_br | (~nonalu_excpirq_flush_req_raw & ~(cmt_i_bxx & fifo_full));
    else
      cmt_i_ready = ~is_br;
  end

  assign accept    = cmt_i_valid & cmt_i_ready;
  assign push      = accept & cmt_i_bxx;
  assign pop       = ~fifo_empty & bht_upd_ready;

  assign next_pc   = cmt_i_pc + (cmt_i_rv32 ? PC_W'(4) : PC_W'(2));

  always_comb begin
    target_pc = next_pc;
    if (cmt_i_mret)
      target_pc = csr_epc_r;
    else if (cmt_i_dret)
      target_pc = csr_dpc_r;
    else if (cmt_i_bjp & ~cmt_i_bjp_prdt)
      target_pc = cmt_i_pc + imm_pc;
  end

  // A pending non-ALU flush masks the request in the same cycle and cancels it.
  assign brchmis_flush_req = (state_q == ST_REQ) & ~nonalu_excpirq_flush_req_raw;
  assign brchmis_flush_pc  = flush_pc_q;
  assign flush_hsk         = brchmis_flush_req & brchmis_flush_ack;

  assign cmt_mret_ena      = flush_hsk & mret_q;
  assign cmt_dret_ena      = flush_hsk & dret_q;
  assign cmt_fencei_ena    = flush_hsk & fencei_q;

  always_comb begin
    state_d    = state_q;
    flush_pc_d = flush_pc_q;
    mret_d     = mret_q;
    dret_d     = dret_q;
    fencei_d   = fencei_q;
    case (state_q)
      ST_IDLE: begin
        if (accept & need_flush) begin
          state_d    = ST_REQ;
          flush_pc_d = target_pc;
          mret_d     = cmt_i_mret;
          dret_d     = cmt_i_dret;
          fencei_d   = cmt_i_fencei;
        end
      end
      ST_REQ: begin
        if (nonalu_excpirq_flush_req_raw | brchmis_flush_ack)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push)
      mem_d[wptr_q] = {cmt_i_pc, cmt_i_bjp_rslv, bxx_mis};
    wptr_d = wptr_q + PTR_W'(push);
    rptr_d = rptr_q + PTR_W'(pop);
    cnt_d  = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  assign bht_upd_valid = ~fifo_empty;
  assign {bht_upd_pc, bht_upd_taken, bht_upd_mis} = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      flush_pc_q <= '0;
      mret_q     <= 1'b0;
      dret_q     <= 1'b0;
      fencei_q   <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < UPD_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      flush_pc_q <= flush_pc_d;
      mret_q     <= mret_d;
      dret_q     <= dret_d;
      fencei_q   <= fencei_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < UPD_DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

`ifdef E203_BRSLV_PERF_CNT_EN
  logic [CNT_W-1:0] bxx_cnt_q, bxx_cnt_d;
  logic [CNT_W-1:0] bxxmis_cnt_q, bxxmis_cnt_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    bxx_cnt_d    = bxx_cnt_q;
    bxxmis_cnt_d = bxxmis_cnt_q;
    if (push) begin
      if (!bxx_mis) begin
        if (!(&bxx_cnt_q))
          bxx_cnt_d = bxx_cnt_q + CNT_W'(1);
      end else if (!(&bxxmis_cnt_q)) begin
        bxxmis_cnt_d = bxxmis_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bxx_cnt_q    <= '0;
      bxxmis_cnt_q <= '0;
    end else begin
      bxx_cnt_q    <= bxx_cnt_d;
      bxxmis_cnt_q <= bxxmis_cnt_d;
    end
  end

  assign perf_bxx_cnt    = bxx_cnt_q;
  assign perf_bxxmis_cnt = bxxmis_cnt_q;
`else
  assign perf_bxx_cnt    = '0;
  assign perf_bxxmis_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_e203_exu_brslv_q.sv
`default_nettype none
// ============================================================================
// tb_e203_exu_brslv_q : directed self-checking bench for e203_exu_brslv_q.  Rev 1.0
// ============================================================================
module tb_e203_exu_brslv_q;

  localparam int PC_W      = 32;
  localparam int XLEN      = 32;
  localparam int UPD_DEPTH = 4;
  localparam int CNT_W     = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmt_i_valid, cmt_i_ready, cmt_i_rv32;
  logic             cmt_i_bjp, cmt_i_bxx, cmt_i_fencei, cmt_i_mret, cmt_i_dret;
  logic             cmt_i_bjp_prdt, cmt_i_bjp_rslv;
  logic [PC_W-1:0]  cmt_i_pc;
  logic [XLEN-1:0]  cmt_i_imm;
  logic [PC_W-1:0]  csr_epc_r, csr_dpc_r;
  logic             nonalu_raw;
  logic             flush_req, flush_ack;
  logic [PC_W-1:0]  flush_pc;
  logic             mret_ena, dret_ena, fencei_ena;
  logic             bht_valid, bht_ready;
  logic [PC_W-1:0]  bht_pc;
  logic             bht_taken, bht_mis;
  logic [CNT_W-1:0] perf_hit, perf_mis;

  int n_chk = 0;
  int n_bad = 0;

  e203_exu_brslv_q #(
    .PC_W(PC_W), .XLEN(XLEN), .UPD_DEPTH(UPD_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .cmt_i_valid                  (cmt_i_valid),
    .cmt_i_ready                  (cmt_i_ready),
    .cmt_i_rv32                   (cmt_i_rv32),
    .cmt_i_bjp                    (cmt_i_bjp),
    .cmt_i_bxx                    (cmt_i_bxx),
    .cmt_i_fencei                 (cmt_i_fencei),
    .cmt_i_mret                   (cmt_i_mret),
    .cmt_i_dret                   (cmt_i_dret),
    .cmt_i_bjp_prdt               (cmt_i_bjp_prdt),
    .cmt_i_bjp_rslv               (cmt_i_bjp_rslv),
    .cmt_i_pc                     (cmt_i_pc),
    .cmt_i_imm                    (cmt_i_imm),
    .csr_epc_r                    (csr_epc_r),
    .csr_dpc_r                    (csr_dpc_r),
    .nonalu_excpirq_flush_req_raw (nonalu_raw),
    .brchmis_flush_req            (flush_req),
    .brchmis_flush_ack            (flush_ack),
    .brchmis_flush_pc             (flush_pc),
    .cmt_mret_ena                 (mret_ena),
    .cmt_dret_ena                 (dret_ena),
    .cmt_fencei_ena               (fencei_ena),
    .bht_upd_valid                (bht_valid),
    .bht_upd_ready                (bht_ready),
    .bht_upd_pc                   (bht_pc),
    .bht_upd_taken                (bht_taken),
    .bht_upd_mis                  (bht_mis),
    .perf_bxx_cnt                 (perf_hit),
    .perf_bxxmis_cnt              (perf_mis)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    cmt_i_valid = 0; cmt_i_rv32 = 1; cmt_i_bjp = 0; cmt_i_bxx = 0;
    cmt_i_fencei = 0; cmt_i_mret = 0; cmt_i_dret = 0;
    cmt_i_bjp_prdt = 0; cmt_i_bjp_rslv = 0; cmt_i_pc = '0; cmt_i_imm = '0;
  endtask

  task automatic br(input logic bxx, input logic prdt, input logic rslv, input logic rv32,
                    input logic [31:0] pc, input logic [31:0] imm);
    clr();
    cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_bxx = bxx;
    cmt_i_bjp_prdt = prdt; cmt_i_bjp_rslv = rslv; cmt_i_rv32 = rv32;
    cmt_i_pc = pc; cmt_i_imm = imm;
  endtask

  logic [CNT_W-1:0] exp_hit, exp_mis;

  initial begin
    rst_n = 0; clr(); flush_ack = 0; bht_ready = 0; nonalu_raw = 0;
    csr_epc_r = 32'h8000_0010; csr_dpc_r = 32'h0000_0900;
    repeat (3) @(posedge clk);
    #2;
    settle();
    check_val("rst_req", flush_req, 0);
    check_val("rst_pc", flush_pc, 0);
    check_val("rst_bht_valid", bht_valid, 0);
    check_val("rst_mret_ena", mret_ena, 0);
    check_val("rst_ready", cmt_i_ready, 1);
    check_val("rst_perf_hit", perf_hit, 0);
    rst_n = 1;

    // beq taken but predicted not-taken; ack two cycles after accept
    tick(); br(1, 0, 1, 1, 32'h100, 32'h40); settle();
    check_val("t1_ready", cmt_i_ready, 1);
    tick(); clr(); settle();
    check_val("t1_req_n1", flush_req, 1);
    check_val("t1_pc", flush_pc, 32'h140);
    check_val("t1_bht_valid", bht_valid, 1);
    check_val("t1_bht_pc", bht_pc, 32'h100);
    check_val("t1_bht_taken", bht_taken, 1);
    check_val("t1_bht_mis", bht_mis, 1);
    cmt_i_valid = 1; settle();
    check_val("t1_nonbr_ready", cmt_i_ready, 1);
    br(0, 0, 0, 1, 32'h180, 0); settle();
    check_val("t1_br_stall", cmt_i_ready, 0);
    clr();
    tick(); settle();
    check_val("t1_req_n2", flush_req, 1);
    flush_ack = 1; settle();
    check_val("t1_no_ena", {mret_ena, dret_ena, fencei_ena}, 0);
    tick(); flush_ack = 0; settle();
    check_val("t1_req_done", flush_req, 0);
    bht_ready = 1;
    tick(); bht_ready = 0; settle();
    check_val("t1_fifo_drained", bht_valid, 0);

    // c.bnez predicted taken, resolved not-taken -> fall-through +2
    tick(); br(1, 1, 0, 0, 32'h200, 32'h20);
    tick(); clr(); settle();
    check_val("t2_req", flush_req, 1);
    check_val("t2_pc", flush_pc, 32'h202);
    flush_ack = 1;
    tick(); flush_ack = 0; br(1, 1, 1, 1, 32'h300, 32'h20); settle();
    check_val("t2_hit_ready", cmt_i_ready, 1);
    tick(); clr(); settle();
    check_val("t2_hit_noreq", flush_req, 0);
    check_val("t2_pc_kept", flush_pc, 32'h202);
    check_val("t2_head_pc", bht_pc, 32'h200);
    check_val("t2_head_tk", {bht_taken, bht_mis}, 2'b01);
    bht_ready = 1;
    tick(); settle();
    check_val("t2_head2_pc", bht_pc, 32'h300);
    check_val("t2_head2_tk", {bht_taken, bht_mis}, 2'b10);
    tick(); bht_ready = 0; settle();
    check_val("t2_empty", bht_valid, 0);

    // mret with ack in the first REQ cycle
    tick(); clr(); cmt_i_valid = 1; cmt_i_mret = 1; cmt_i_pc = 32'h600;
    tick(); clr(); flush_ack = 1; settle();
    check_val("t3_req", flush_req, 1);
    check_val("t3_pc", flush_pc, 32'h8000_0010);
    check_val("t3_mret_ena", mret_ena, 1);
    check_val("t3_other_ena", {dret_ena, fencei_ena}, 0);
    tick(); flush_ack = 0; settle();
    check_val("t3_mret_ena_off", mret_ena, 0);
    check_val("t3_req_off", flush_req, 0);

    // dret target and pulse
    tick(); clr(); cmt_i_valid = 1; cmt_i_dret = 1; cmt_i_pc = 32'h640;
    tick(); clr(); flush_ack = 1; settle();
    check_val("t3d_pc", flush_pc, 32'h900);
    check_val("t3d_dret_ena", {mret_ena, dret_ena, fencei_ena}, 3'b010);
    tick(); flush_ack = 0;

    // fencei request abandoned by a non-ALU flush
    clr(); cmt_i_valid = 1; cmt_i_fencei = 1; cmt_i_pc = 32'h400;
    tick(); clr(); settle();
    check_val("t4_req", flush_req, 1);
    check_val("t4_pc", flush_pc, 32'h404);
    nonalu_raw = 1; flush_ack = 1; settle();
    check_val("t4_req_drop", flush_req, 0);
    check_val("t4_no_ena", fencei_ena, 0);
    tick(); flush_ack = 0; settle();
    check_val("t4_idle_req", flush_req, 0);
    br(1, 0, 0, 1, 32'h480, 0); settle();
    check_val("t4_nonalu_stall", cmt_i_ready, 0);
    clr(); nonalu_raw = 0;
    tick(); settle();
    check_val("t4_stays_idle", flush_req, 0);

    // fill the update queue, then stall the fifth bxx until space frees
    for (int i = 0; i < 4; i++) begin
      br(1, i[0], i[0], 1, 32'h1000 + 32'(4 * i), 0); settle();
      check_val("t5_push_ready", cmt_i_ready, 1);
      tick();
    end
    br(1, 0, 0, 1, 32'h1010, 0); bht_ready = 1; settle();
    check_val("t5_full_stall", cmt_i_ready, 0);
    check_val("t5_head0", bht_pc, 32'h1000);
    tick(); bht_ready = 0; settle();
    check_val("t5_space_ready", cmt_i_ready, 1);
    tick(); clr(); bht_ready = 1;
    for (int i = 1; i < 5; i++) begin
      settle();
      check_val("t5_order_pc", bht_pc, 32'h1000 + 32'(4 * i));
      check_val("t5_order_tk", bht_taken, (i == 4) ? 1'b0 : i[0]);
      tick();
    end
    bht_ready = 0; settle();
    check_val("t5_empty", bht_valid, 0);

    // fresh counters, PC wrap-around, then async reset while in REQ
    rst_n = 0; settle(); rst_n = 1;
    bht_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); br(1, 1, 1, 1, 32'h700 + 32'(4 * i), 0);
    end
    tick(); br(1, 1, 0, 1, 32'h500, 32'h10);
    tick(); clr(); settle();
    check_val("t6_miss_pc", flush_pc, 32'h504);
    flush_ack = 1;
    tick(); flush_ack = 0; br(1, 0, 1, 1, 32'hFFFF_FFFC, 32'h8);
    tick(); clr(); bht_ready = 0; settle();
    check_val("t6_wrap_req", flush_req, 1);
    check_val("t6_wrap_pc", flush_pc, 32'h4);
`ifdef E203_BRSLV_PERF_CNT_EN
    exp_hit = 3; exp_mis = 2;
`else
    exp_hit = 0; exp_mis = 0;
`endif
    check_val("t6_perf_hit", perf_hit, exp_hit);
    check_val("t6_perf_mis", perf_mis, exp_mis);
    check_val("t6_fifo_busy", bht_valid, 1);
    rst_n = 0; settle();
    check_val("t6_rst_req", flush_req, 0);
    check_val("t6_rst_pc", flush_pc, 0);
    check_val("t6_rst_fifo", bht_valid, 0);
    check_val("t6_rst_perf", {perf_hit, perf_mis}, 0);
    tick(); rst_n = 1;
    tick(); settle();
    check_val("t6_after_rst_req", flush_req, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
